// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing defaults, FSM state encoding and bit-period derivation
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_STOP      = 3'd3;
  localparam state_t ST_WAIT_HIGH = 3'd4;

  function automatic int calc_bit_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud - 1;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer for the serial line with falling-edge detect
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic fall
);

  logic meta;
  logic prev;

  // All flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver sampling each bit at its mid-point
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_err
);

  localparam int BIT_CNT_MAX = calc_bit_cnt_max(CLK_FREQ, BAUD);
  localparam int HALF_CNT    = calc_half_cnt(CLK_FREQ, BAUD);
  localparam int CW          = $clog2(CLK_FREQ / BAUD);

  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_CNT_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CNT);

  logic          rx_s;
  logic          fall;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;

  sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rs232),
    .q    (rx_s),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= 8'h00;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (state != ST_IDLE)
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        // Restarting at the start-bit mid-point puts every later wrap on a bit mid-point.
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_MAX) begin
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 4'd7) begin
              bit_idx <= '0;
              cnt     <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shift;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end
        end
        // A held-low line (break) must return high before a new start edge counts.
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with 100 clocks per bit
module tb_uart_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int LAT      = BIT * 19 / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs232 = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_viol = 0;
  int stable_viol = 0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] done_q[$];
  int         done_cyc_q[$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232     (rs232),
    .data      (data),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_q.push_back(data);
      done_cyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (done && frame_err) both_viol++;
    if (!rst && !done && data !== data_prev) stable_viol++;
    data_prev = data;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rs232 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(b[i], per);
    drive(stop, per);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         per;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, f0, lat;
    int starts[3];
    logic [7:0] b2b[3];

    vecs[0] = '{8'hA5, 1'b1, BIT,       1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, BIT + 2,   1, 0, 8'h5A};
    vecs[2] = '{8'h5A, 1'b1, BIT - 2,   1, 0, 8'h5A};
    vecs[3] = '{8'h3C, 1'b0, BIT,       0, 1, 8'h5A};
    vecs[4] = '{8'hC3, 1'b1, BIT,       1, 0, 8'hC3};
    b2b = '{8'h00, 8'hFF, 8'h55};

    repeat (5) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_done", done, 0);
    check("reset_ferr", frame_err, 0);
    rst = 1'b0;
    drive(1'b1, 20);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[v].tx, vecs[v].stop, vecs[v].per);
      drive(1'b1, 2 * BIT);
      check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
    end

    d0 = done_cnt;
    f0 = ferr_cnt;
    drive(1'b0, 19);
    drive(1'b1, 3 * BIT);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_data", data, 8'hC3);

    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BIT);
    drive(1'b0, 4 * BIT);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_data", data, 8'hC3);
    drive(1'b1, 2 * BIT);
    check("break_done", done_cnt - d0, 0);
    send_frame(8'h81, 1'b1, BIT);
    drive(1'b1, 2 * BIT);
    check("after_break_done", done_cnt - d0, 1);
    check("after_break_ferr", ferr_cnt - f0, 1);
    check("after_break_data", data, 8'h81);

    done_q.delete();
    done_cyc_q.delete();
    for (int k = 0; k < 3; k++) begin
      starts[k] = cyc;
      send_frame(b2b[k], 1'b1, BIT);
    end
    drive(1'b1, 2 * BIT);
    check("b2b_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("b2b%0d_data", k), done_q[k], b2b[k]);
        lat = done_cyc_q[k] - (starts[k] + 2);
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          errors++;
          $display("FAIL b2b%0d_latency actual=%0d expected=%0d+-1", k, lat, LAT);
        end
      end
    end

    d0 = done_cnt;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(i >= 4, BIT);
    drive(1'b1, BIT / 3);
    rst = 1'b1;
    drive(1'b1, 5);
    check("midrst_data", data, 8'h00);
    rst = 1'b0;
    drive(1'b1, 6 * BIT);
    check("midrst_done", done_cnt - d0, 0);
    send_frame(8'h0F, 1'b1, BIT);
    drive(1'b1, 2 * BIT);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_data", data, 8'h0F);

    check("done_ferr_exclusive", both_viol, 0);
    check("data_stable", stable_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
